// File: rtl/pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// pipe_stage_skid
//
// Pipeline register between the execute stage and the memory/writeback stage.
// It carries the ALU result, the register write address and the memory-control
// bits over a valid/ready handshake. A two-entry buffer (main + skid) keeps one
// transfer per cycle, so in_ready depends only on registered state plus the
// freeze gate.
// The stage also supports a flush that kills held entries and a sticky halt
// flag that closes the input once a halt entry has left.
//
// Optional feature macro: PIPE_STAGE_PERF_EN adds the saturating stall_cnt
// output.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   freeze            global stall; blocks both handshakes and holds state
//   flush             drops every held entry at the next edge
//   in_valid/in_ready upstream handshake
//   in_halted, in_data_rw, in_mem_write, in_alu, in_waddr   upstream payload
//   out_valid/out_ready downstream handshake
//   out_halted, out_data_rw, out_mem_write, out_alu, out_waddr  main entry
//   halted_seen       sticky: a halt entry has been emitted
//   stall_cnt         (PIPE_STAGE_PERF_EN only) cycles main was held back
// -----------------------------------------------------------------------------
module pipe_stage_skid #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 6,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              freeze,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_halted,
   input  logic              in_data_rw,
   input  logic              in_mem_write,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [ADDR_W-1:0] in_waddr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_halted,
   output logic              out_data_rw,
   output logic              out_mem_write,
   output logic [DATA_W-1:0] out_alu,
   output logic [ADDR_W-1:0] out_waddr,
   output logic              halted_seen
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt
`endif
);

   // Payload layout: {halted, data_rw, mem_write, alu, waddr}
   localparam int PAY_W = 3 + DATA_W + ADDR_W;
   localparam int HALT_BIT = PAY_W - 1;

   logic             main_valid_q, main_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic [PAY_W-1:0] main_pay_q,   main_pay_d;
   logic [PAY_W-1:0] skid_pay_q,   skid_pay_d;
   logic             halted_seen_q, halted_seen_d;
   logic [PAY_W-1:0] in_pay;
   logic             accept;
   logic             emit;

   assign in_pay = {in_halted, in_data_rw, in_mem_write, in_alu, in_waddr};

   // Handshakes are gated by freeze; the skid slot being full closes the input.
   assign in_ready  = !skid_valid_q && !freeze && !halted_seen_q;
   assign out_valid = main_valid_q && !freeze;
   assign accept    = in_valid && in_ready;
   assign emit      = out_valid && out_ready;

   // Next-state logic for the two buffer slots and the sticky halt flag.
   always_comb begin
      main_valid_d  = main_valid_q;
      skid_valid_d  = skid_valid_q;
      main_pay_d    = main_pay_q;
      skid_pay_d    = skid_pay_q;
      // emit is already 0 under freeze, so this holds while frozen.
      halted_seen_d = halted_seen_q | (emit & main_pay_q[HALT_BIT]);
      if (freeze) begin
         main_valid_d = main_valid_q;
         skid_valid_d = skid_valid_q;
      end else if (flush) begin
         // Payload fields are left stale; only the valid bits matter.
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
      end else if (!main_valid_q) begin
         // Skid is never occupied while main is empty.
         if (accept) begin
            main_valid_d = 1'b1;
            main_pay_d   = in_pay;
         end else begin
            main_valid_d = 1'b0;
         end
      end else if (emit) begin
         if (skid_valid_q) begin
            // in_ready was low, so no accept can race the skid refill.
            main_pay_d   = skid_pay_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            main_pay_d   = in_pay;
         end else begin
            main_valid_d = 1'b0;
         end
      end else begin
         // Main is blocked: a new entry parks in the skid slot.
         if (accept) begin
            skid_valid_d = 1'b1;
            skid_pay_d   = in_pay;
         end else begin
            skid_valid_d = skid_valid_q;
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         main_valid_q  <= 1'b0;
         skid_valid_q  <= 1'b0;
         main_pay_q    <= {PAY_W{1'b0}};
         skid_pay_q    <= {PAY_W{1'b0}};
         halted_seen_q <= 1'b0;
      end else begin
         main_valid_q  <= main_valid_d;
         skid_valid_q  <= skid_valid_d;
         main_pay_q    <= main_pay_d;
         skid_pay_q    <= skid_pay_d;
         halted_seen_q <= halted_seen_d;
      end
   end

   assign out_halted    = main_pay_q[HALT_BIT];
   assign out_data_rw   = main_pay_q[HALT_BIT-1];
   assign out_mem_write = main_pay_q[HALT_BIT-2];
   assign out_alu       = main_pay_q[ADDR_W +: DATA_W];
   assign out_waddr     = main_pay_q[ADDR_W-1:0];
   assign halted_seen   = halted_seen_q;

`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // Stall counter: counts held-back cycles, including frozen ones, and saturates.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (main_valid_q && (freeze || !out_ready) && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         stall_cnt_d = stall_cnt_q;
      end
   end

   // Stall counter register; flush leaves it alone.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_q <= {CNT_W{1'b0}};
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_skid
// Self-checking bench: directed scenarios with literal expectations, followed by
// randomized traffic. A queue-based reference model tracks the held entries.
// -----------------------------------------------------------------------------
module tb_pipe_stage_skid;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 6;
   localparam int CNT_W  = 16;

   typedef struct packed {
      logic              halted;
      logic              rw;
      logic              mw;
      logic [DATA_W-1:0] alu;
      logic [ADDR_W-1:0] waddr;
   } entry_t;

   logic              clk = 1'b0;
   logic              rst_n, freeze, flush, in_valid, in_ready;
   logic              in_halted, in_data_rw, in_mem_write;
   logic [DATA_W-1:0] in_alu;
   logic [ADDR_W-1:0] in_waddr;
   logic              out_valid, out_ready, out_halted, out_data_rw, out_mem_write;
   logic [DATA_W-1:0] out_alu;
   logic [ADDR_W-1:0] out_waddr;
   logic              halted_seen;
`ifdef PIPE_STAGE_PERF_EN
   logic [CNT_W-1:0]  stall_cnt;
`endif

   int checks = 0;
   int errors = 0;

   // Reference model state
   entry_t q_m[$];
   logic   hs_m;
   int     cnt_m;

   always #5 clk = ~clk;

   pipe_stage_skid #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .freeze(freeze), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_halted(in_halted),
      .in_data_rw(in_data_rw), .in_mem_write(in_mem_write),
      .in_alu(in_alu), .in_waddr(in_waddr),
      .out_valid(out_valid), .out_ready(out_ready), .out_halted(out_halted),
      .out_data_rw(out_data_rw), .out_mem_write(out_mem_write),
      .out_alu(out_alu), .out_waddr(out_waddr), .halted_seen(halted_seen)
`ifdef PIPE_STAGE_PERF_EN
      , .stall_cnt(stall_cnt)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle's worth of inputs; rw/mw derive from alu bits.
   task automatic drive(input logic rst, input logic frz, input logic fl, input logic iv,
                        input logic [7:0] alu, input logic [5:0] wa, input logic h,
                        input logic ordy);
      rst_n        = rst;
      freeze       = frz;
      flush        = fl;
      in_valid     = iv;
      in_alu       = alu;
      in_waddr     = wa;
      in_halted    = h;
      in_data_rw   = alu[0];
      in_mem_write = alu[1];
      out_ready    = ordy;
   endtask

   // Compare against the model mid-cycle, then advance model and DUT one edge.
   task automatic step();
      entry_t cur;
      logic   em, ac;
      @(negedge clk);
      check("in_ready", {31'd0, in_ready}, {31'd0, (q_m.size() < 2) && !freeze && !hs_m});
      check("out_valid", {31'd0, out_valid}, {31'd0, (q_m.size() > 0) && !freeze});
      check("halted_seen", {31'd0, halted_seen}, {31'd0, hs_m});
      if (q_m.size() > 0) begin
         check("out_payload",
               {17'd0, out_halted, out_data_rw, out_mem_write, out_alu, out_waddr},
               {17'd0, q_m[0]});
      end
`ifdef PIPE_STAGE_PERF_EN
      check("stall_cnt", {16'd0, stall_cnt}, cnt_m);
`endif
      cur = '{halted: in_halted, rw: in_data_rw, mw: in_mem_write, alu: in_alu, waddr: in_waddr};
      @(posedge clk);
      if (!rst_n) begin
         q_m.delete();
         hs_m  = 1'b0;
         cnt_m = 0;
      end else begin
         if (q_m.size() > 0 && (freeze || !out_ready) && cnt_m < 65535) cnt_m++;
         if (!freeze) begin
            em = (q_m.size() > 0) && out_ready;
            ac = in_valid && (q_m.size() < 2) && !hs_m;
            if (em && q_m[0].halted) hs_m = 1'b1;
            if (flush) begin
               q_m.delete();
            end else begin
               if (em) void'(q_m.pop_front());
               if (ac) q_m.push_back(cur);
            end
         end
      end
      #1;
   endtask

   initial begin
      q_m.delete();
      hs_m  = 1'b0;
      cnt_m = 0;
      drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h99, 6'd9, 1'b0, 1'b1);
      #1;
      // Reset held two cycles with in_valid high
      step(); step();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 6'd0, 1'b0, 1'b1); #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_alu", {24'd0, out_alu}, 32'h0);
      check("rst_halted_seen", {31'd0, halted_seen}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Streaming, one per cycle
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h11, 6'd1, 1'b0, 1'b1); step();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h22, 6'd2, 1'b0, 1'b1); #1;
      check("stream_0x11", {24'd0, out_alu}, 32'h11);
      check("stream_waddr1", {26'd0, out_waddr}, 32'd1);
      step();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h33, 6'd3, 1'b0, 1'b1); #1;
      check("stream_0x22", {24'd0, out_alu}, 32'h22);
      check("stream_valid2", {31'd0, out_valid}, 32'd1);
      step();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 6'd0, 1'b0, 1'b1); #1;
      check("stream_0x33", {24'd0, out_alu}, 32'h33);
      check("stream_waddr3", {26'd0, out_waddr}, 32'd3);
      step(); #1;
      check("stream_drained", {31'd0, out_valid}, 32'd0);

      // Backpressure into the skid slot
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hA1, 6'd4, 1'b0, 1'b0); step();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hA2, 6'd5, 1'b0, 1'b0); #1;
      check("bp_ready_cycle2", {31'd0, in_ready}, 32'd1);
      step();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'hA3, 6'd6, 1'b0, 1'b0); #1;
      check("bp_ready_cycle3", {31'd0, in_ready}, 32'd0);
      step();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 6'd0, 1'b0, 1'b1); #1;
      check("bp_first_A1", {24'd0, out_alu}, 32'hA1);
      step();
      check("bp_second_A2", {24'd0, out_alu}, 32'hA2);
      check("bp_ready_back", {31'd0, in_ready}, 32'd1);
      step();
      check("bp_no_A3", {31'd0, out_valid}, 32'd0);

      // Freeze with 0x55 held
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 6'd7, 1'b0, 1'b0); step();
      drive(1'b1, 1'b1, 1'b0, 1'b1, 8'h66, 6'd8, 1'b0, 1'b1); #1;
      check("frz_out_valid", {31'd0, out_valid}, 32'd0);
      check("frz_in_ready", {31'd0, in_ready}, 32'd0);
      step(); step(); step();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 6'd0, 1'b0, 1'b1); #1;
      check("frz_release_0x55", {24'd0, out_alu}, 32'h55);
      check("frz_release_valid", {31'd0, out_valid}, 32'd1);
      step();
      check("frz_once", {31'd0, out_valid}, 32'd0);

      // Flush with both slots full
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h10, 6'd1, 1'b0, 1'b0); step();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h20, 6'd2, 1'b0, 1'b0); step();
      drive(1'b1, 1'b0, 1'b1, 1'b1, 8'h30, 6'd3, 1'b0, 1'b0); step();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 6'd0, 1'b0, 1'b1); #1;
      check("flush_out_valid", {31'd0, out_valid}, 32'd0);
      check("flush_in_ready", {31'd0, in_ready}, 32'd1);
      check("flush_hs", {31'd0, halted_seen}, 32'd0);
      step();

      // Halt entry followed by 0x80
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h7F, 6'd1, 1'b1, 1'b1); step();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h80, 6'd2, 1'b0, 1'b1); step();
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h81, 6'd3, 1'b0, 1'b1); #1;
      check("halt_seen", {31'd0, halted_seen}, 32'd1);
      check("halt_in_ready", {31'd0, in_ready}, 32'd0);
      check("halt_drain_0x80", {24'd0, out_alu}, 32'h80);
      step();
      check("halt_no_0x81", {31'd0, out_valid}, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 6'd0, 1'b0, 1'b1); step();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 6'd0, 1'b0, 1'b1); #1;
      check("halt_reset_clears", {31'd0, halted_seen}, 32'd0);

      // Stall counting with main held
      drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h44, 6'd4, 1'b0, 1'b0); step();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 6'd0, 1'b0, 1'b0);
      step(); step(); step(); step();
`ifdef PIPE_STAGE_PERF_EN
      check("stall_cnt_4", {16'd0, stall_cnt}, 32'd4);
`endif
      check("stall_held_0x44", {24'd0, out_alu}, 32'h44);

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         drive(($urandom_range(199) != 0),
               ($urandom_range(7) == 0),
               ($urandom_range(15) == 0),
               ($urandom_range(2) != 0),
               8'($urandom),
               6'($urandom),
               ($urandom_range(39) == 0),
               ($urandom_range(2) != 0));
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
